// File: rtl/mem_req_if.sv
// Request/memory/response bundle of the memory request unit.
// slave is the unit's view; master is the controller-and-memory side.
interface mem_req_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err_valid;
    logic [1:0]  err_code;

    modport slave (
        input  req_valid, req_type, req_funct3, req_addr, req_wdata, mem_resp, mem_rdata,
        output req_ready, mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        output resp_valid, resp_rdata, err_valid, err_code
    );

    modport master (
        output req_valid, req_type, req_funct3, req_addr, req_wdata, mem_resp, mem_rdata,
        input  req_ready, mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata,
        input  resp_valid, resp_rdata, err_valid, err_code
    );
endinterface

// File: rtl/mem_req_unit.sv
// Single-outstanding memory request unit: classifies fetch/load/store requests,
// drives aligned word accesses with lane enables, and reports completion, errors and timeouts.
module mem_req_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic      clk,
    input  logic      rst,
    mem_req_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [1:0]  TYPE_STORE   = 2'b10;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    function automatic logic is_illegal(input logic [1:0] t, input logic [2:0] f3);
        logic ill;
        ill = 1'b0;
        case (t)
            2'b00:   ill = 1'b0;
            2'b01:   ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            2'b10:   ill = (f3 >= 3'b011);
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction

    // Fetches are always word accesses; funct3 low bits give the width of loads/stores.
    function automatic logic is_misaligned(input logic [1:0] t, input logic [1:0] w,
                                           input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (t)
            2'b00: mis = (a != 2'b00);
            2'b01, 2'b10: begin
                case (w)
                    2'b01:   mis = a[0];
                    2'b10:   mis = (a != 2'b00);
                    default: mis = 1'b0;
                endcase
            end
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_enable(input logic [1:0] t, input logic [1:0] w,
                                               input logic [1:0] a);
        logic [3:0] be;
        be = 4'b1111;
        if (t == TYPE_STORE) begin
            case (w)
                2'b00:   be = 4'b0001 << a;
                2'b01:   be = 4'b0011 << a;
                default: be = 4'b1111;
            endcase
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] w, input logic [1:0] a,
                                                input logic [31:0] wd);
        logic [31:0] d;
        d = 32'h0000_0000;
        case (w)
            2'b00:   d = {24'h00_0000, wd[7:0]} << {a, 3'b000};
            2'b01:   d = {16'h0000, wd[15:0]} << {a[1], 4'b0000};
            default: d = wd;
        endcase
        return d;
    endfunction

    logic [1:0]  state_r;
    logic        req_ready_r;
    logic [1:0]  type_r;
    logic [15:0] cnt_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic [31:0] mem_address_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_wdata_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        err_valid_r;
    logic [1:0]  err_code_r;

    logic        accept_s;
    logic        illegal_s;
    logic        misaligned_s;
    logic        timeout_s;
    logic [1:0]  state_nx_s;

    // Request classification and timeout detection.
    always_comb begin
        accept_s     = bus.req_valid && req_ready_r;
        illegal_s    = is_illegal(bus.req_type, bus.req_funct3);
        misaligned_s = is_misaligned(bus.req_type, bus.req_funct3[1:0], bus.req_addr[1:0]);
        timeout_s    = (cnt_r == TIMEOUT_LAST) && !bus.mem_resp;
    end

    // Next-state logic; a response in the last allowed cycle beats the timeout.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = (illegal_s || misaligned_s) ? ERR : REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (bus.mem_resp) begin
                    state_nx_s = DONE;
                end else if (timeout_s) begin
                    state_nx_s = ERR;
                end else begin
                    state_nx_s = REQ;
                end
            end
            DONE:    state_nx_s = IDLE;
            ERR:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, captured request and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            req_ready_r   <= 1'b1;
            type_r        <= 2'b00;
            cnt_r         <= 16'h0000;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_address_r <= 32'h0000_0000;
            mem_be_r      <= 4'b0000;
            mem_wdata_r   <= 32'h0000_0000;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= 32'h0000_0000;
            err_valid_r   <= 1'b0;
            err_code_r    <= 2'b00;
        end else begin
            state_r      <= state_nx_s;
            req_ready_r  <= (state_nx_s == IDLE);
            resp_valid_r <= (state_nx_s == DONE);
            err_valid_r  <= (state_nx_s == ERR);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        type_r       <= bus.req_type;
                        cnt_r        <= 16'h0000;
                        resp_rdata_r <= 32'h0000_0000;
                        if (illegal_s) begin
                            err_code_r <= 2'b10;
                        end else if (misaligned_s) begin
                            err_code_r <= 2'b01;
                        end else begin
                            err_code_r    <= 2'b00;
                            mem_read_r    <= (bus.req_type != TYPE_STORE);
                            mem_write_r   <= (bus.req_type == TYPE_STORE);
                            mem_address_r <= {bus.req_addr[31:2], 2'b00};
                            mem_be_r      <= lane_enable(bus.req_type, bus.req_funct3[1:0],
                                                         bus.req_addr[1:0]);
                            mem_wdata_r   <= (bus.req_type == TYPE_STORE)
                                             ? store_lanes(bus.req_funct3[1:0], bus.req_addr[1:0],
                                                           bus.req_wdata)
                                             : 32'h0000_0000;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_resp) begin
                        mem_read_r   <= 1'b0;
                        mem_write_r  <= 1'b0;
                        resp_rdata_r <= (type_r == TYPE_STORE) ? 32'h0000_0000 : bus.mem_rdata;
                    end else if (timeout_s) begin
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        err_code_r  <= 2'b11;
                    end else begin
                        cnt_r <= cnt_r + 16'h0001;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready_r;
    assign bus.mem_read        = mem_read_r;
    assign bus.mem_write       = mem_write_r;
    assign bus.mem_address     = mem_address_r;
    assign bus.mem_byte_enable = mem_be_r;
    assign bus.mem_wdata       = mem_wdata_r;
    assign bus.resp_valid      = resp_valid_r;
    assign bus.resp_rdata      = resp_rdata_r;
    assign bus.err_valid       = err_valid_r;
    assign bus.err_code        = err_code_r;

endmodule

// File: tb/tb_mem_req_unit.sv
// Scoreboard bench for mem_req_unit (TIMEOUT_CYCLES = 4): stimulus pushes expected
// responses and memory accesses; negedge monitors pop and compare them.
module tb_mem_req_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    mem_req_if bus_if();

    mem_req_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
    } mexp_t;

    exp_t  exp_q[$];
    mexp_t mem_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Memory-side monitor: first strobe cycle, stability while strobed, strobe length.
    initial begin
        mexp_t       cur;
        logic        prev_strobe;
        logic        strobe;
        int          run_len;
        logic [31:0] snap_addr;
        logic [31:0] snap_wdata;
        logic [3:0]  snap_be;
        logic [1:0]  snap_dir;
        prev_strobe = 1'b0;
        run_len = 0;
        cur = '{rd: 1'b0, wr: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0, len: 0};
        forever begin
            @(negedge clk);
            strobe = bus_if.mem_read | bus_if.mem_write;
            check("strobe_exclusive", 32'(bus_if.mem_read & bus_if.mem_write), 32'd0);
            if (strobe && !prev_strobe) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_strobe", 32'(strobe), 32'd0);
                end else begin
                    cur = mem_q.pop_front();
                    check("mem_read", 32'(bus_if.mem_read), 32'(cur.rd));
                    check("mem_write", 32'(bus_if.mem_write), 32'(cur.wr));
                    check("mem_address", bus_if.mem_address, cur.addr);
                    check("mem_byte_enable", 32'(bus_if.mem_byte_enable), 32'(cur.be));
                    if (cur.wr) check("mem_wdata", bus_if.mem_wdata, cur.wdata);
                end
                snap_addr  = bus_if.mem_address;
                snap_wdata = bus_if.mem_wdata;
                snap_be    = bus_if.mem_byte_enable;
                snap_dir   = {bus_if.mem_read, bus_if.mem_write};
                run_len    = 1;
            end else if (strobe && prev_strobe) begin
                run_len++;
                check("hold_address", bus_if.mem_address, snap_addr);
                check("hold_wdata", bus_if.mem_wdata, snap_wdata);
                check("hold_be", 32'(bus_if.mem_byte_enable), 32'(snap_be));
                check("hold_dir", 32'({bus_if.mem_read, bus_if.mem_write}), 32'(snap_dir));
            end else if (!strobe && prev_strobe) begin
                check("strobe_cycles", 32'(run_len), 32'(cur.len));
            end
            prev_strobe = strobe;
        end
    end

    // Response monitor: every resp/err pulse must match the oldest expectation, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (bus_if.resp_valid || bus_if.err_valid)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 32'({bus_if.resp_valid, bus_if.err_valid}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", 32'({bus_if.err_valid, bus_if.resp_valid}),
                          e.is_err ? 32'd2 : 32'd1);
                    if (e.is_err) check("err_code", 32'(bus_if.err_code), 32'(e.code));
                    else          check("resp_rdata", bus_if.resp_rdata, e.rdata);
                    check("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Issue one request at a negedge, queue its expectations, then scramble the inputs.
    task automatic send(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit push_resp, input bit is_err,
                        input logic [31:0] e_rdata, input logic [1:0] e_code, input int lat,
                        input bit has_mem, input bit e_rd, input bit e_wr,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input int e_len);
        int    n;
        exp_t  e;
        mexp_t m;
        n = 0;
        while (bus_if.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 32'(bus_if.req_ready), 32'd1);
        bus_if.req_type   = t;
        bus_if.req_funct3 = f3;
        bus_if.req_addr   = a;
        bus_if.req_wdata  = wd;
        bus_if.req_valid  = 1'b1;
        if (push_resp) begin
            e = '{is_err: is_err, rdata: e_rdata, code: e_code, cyc: cyc + lat};
            exp_q.push_back(e);
        end
        if (has_mem) begin
            m = '{rd: e_rd, wr: e_wr, addr: e_addr, be: e_be, wdata: e_wdata, len: e_len};
            mem_q.push_back(m);
        end
        @(negedge clk);
        bus_if.req_valid  = 1'b0;
        bus_if.req_type   = 2'b11;
        bus_if.req_funct3 = 3'b111;
        bus_if.req_addr   = 32'hFFFF_FFFF;
        bus_if.req_wdata  = 32'hFFFF_FFFF;
    endtask

    // Memory answers in REQ cycle d (0-based); the following negedge is the DONE cycle.
    task automatic mem_reply(input int d, input logic [31:0] rd);
        repeat (d) @(negedge clk);
        bus_if.mem_resp  = 1'b1;
        bus_if.mem_rdata = rd;
        @(negedge clk);
        bus_if.mem_resp  = 1'b0;
        bus_if.mem_rdata = 32'h5A5A_5A5A;
        check("ready_low_in_done", 32'(bus_if.req_ready), 32'd0);
    endtask

    task automatic chk_idle(input bit chk_rd, input logic [31:0] rd,
                            input bit chk_code, input logic [1:0] code);
        @(negedge clk);
        check("ready_after_exit", 32'(bus_if.req_ready), 32'd1);
        if (chk_rd)   check("rdata_hold", bus_if.resp_rdata, rd);
        if (chk_code) check("code_hold", 32'(bus_if.err_code), 32'(code));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, want < 20000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.req_valid  = 1'b0;
        bus_if.req_type   = 2'b00;
        bus_if.req_funct3 = 3'b000;
        bus_if.req_addr   = 32'h0;
        bus_if.req_wdata  = 32'h0;
        bus_if.mem_resp   = 1'b0;
        bus_if.mem_rdata  = 32'h5A5A_5A5A;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(bus_if.req_ready), 32'd1);
        check("reset_ctrl", 32'({bus_if.mem_read, bus_if.mem_write, bus_if.mem_byte_enable,
                                  bus_if.resp_valid, bus_if.err_valid, bus_if.err_code}), 32'd0);
        check("reset_address", bus_if.mem_address, 32'h0);
        check("reset_wdata", bus_if.mem_wdata, 32'h0);
        check("reset_rdata", bus_if.resp_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // fetch 0x60, answered in the third REQ cycle
        send(2'b00, 3'b010, 32'h60, 32'h0, 1, 0, 32'h00A0_0093, 2'b00, 4,
             1, 1, 0, 32'h60, 4'b1111, 32'h0, 3);
        mem_reply(2, 32'h00A0_0093);
        chk_idle(1, 32'h00A0_0093, 0, 2'b00);
        // sb at 0x103: lane 3
        send(2'b10, 3'b000, 32'h103, 32'h1234_56AB, 1, 0, 32'h0, 2'b00, 3,
             1, 0, 1, 32'h100, 4'b1000, 32'hAB00_0000, 2);
        mem_reply(1, 32'hDEAD_BEEF);
        chk_idle(1, 32'h0, 0, 2'b00);
        // sh at 0x102: upper half
        send(2'b10, 3'b001, 32'h102, 32'h0000_BEEF, 1, 0, 32'h0, 2'b00, 2,
             1, 0, 1, 32'h100, 4'b1100, 32'hBEEF_0000, 1);
        mem_reply(0, 32'hDEAD_BEEF);
        chk_idle(1, 32'h0, 0, 2'b00);
        // sw at 0x204
        send(2'b10, 3'b010, 32'h204, 32'hCAFE_F00D, 1, 0, 32'h0, 2'b00, 2,
             1, 0, 1, 32'h204, 4'b1111, 32'hCAFE_F00D, 1);
        mem_reply(0, 32'hDEAD_BEEF);
        chk_idle(1, 32'h0, 0, 2'b00);
        // sb at 0x001: lane 1
        send(2'b10, 3'b000, 32'h001, 32'hFFFF_FF77, 1, 0, 32'h0, 2'b00, 2,
             1, 0, 1, 32'h000, 4'b0010, 32'h0000_7700, 1);
        mem_reply(0, 32'h1111_1111);
        chk_idle(1, 32'h0, 0, 2'b00);
        // lbu at 0x1001: raw word returned
        send(2'b01, 3'b100, 32'h1001, 32'h0, 1, 0, 32'h1122_3344, 2'b00, 3,
             1, 1, 0, 32'h1000, 4'b1111, 32'h0, 2);
        mem_reply(1, 32'h1122_3344);
        chk_idle(1, 32'h1122_3344, 0, 2'b00);

        // classification errors: no strobe, error pulse one cycle after accept
        send(2'b01, 3'b010, 32'h102, 32'h0, 1, 1, 32'h0, 2'b01, 1, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        chk_idle(0, 32'h0, 1, 2'b01);
        send(2'b10, 3'b011, 32'h100, 32'h0, 1, 1, 32'h0, 2'b10, 1, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        chk_idle(0, 32'h0, 1, 2'b10);
        send(2'b11, 3'b010, 32'h100, 32'h0, 1, 1, 32'h0, 2'b10, 1, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        chk_idle(0, 32'h0, 1, 2'b10);
        send(2'b01, 3'b110, 32'h101, 32'h0, 1, 1, 32'h0, 2'b10, 1, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        chk_idle(0, 32'h0, 1, 2'b10);
        send(2'b01, 3'b001, 32'h101, 32'h0, 1, 1, 32'h0, 2'b01, 1, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        chk_idle(0, 32'h0, 1, 2'b01);
        send(2'b10, 3'b001, 32'h001, 32'h0, 1, 1, 32'h0, 2'b01, 1, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        chk_idle(0, 32'h0, 1, 2'b01);
        send(2'b00, 3'b000, 32'h062, 32'h0, 1, 1, 32'h0, 2'b01, 1, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        chk_idle(0, 32'h0, 1, 2'b01);

        // timeout: four strobed cycles then code 11
        send(2'b01, 3'b010, 32'h40, 32'h0, 1, 1, 32'h0, 2'b11, 5,
             1, 1, 0, 32'h40, 4'b1111, 32'h0, 4);
        repeat (4) @(negedge clk);
        chk_idle(0, 32'h0, 1, 2'b11);
        // response in the last allowed cycle wins over the timeout
        send(2'b01, 3'b010, 32'h40, 32'h0, 1, 0, 32'h0BAD_F00D, 2'b00, 5,
             1, 1, 0, 32'h40, 4'b1111, 32'h0, 4);
        mem_reply(3, 32'h0BAD_F00D);
        chk_idle(1, 32'h0BAD_F00D, 0, 2'b00);

        // mem_resp while idle is ignored
        bus_if.mem_resp = 1'b1;
        @(negedge clk);
        bus_if.mem_resp = 1'b0;
        check("idle_resp_ignored", 32'(bus_if.resp_valid), 32'd0);

        // reset in the second REQ cycle, late mem_resp must not complete anything
        send(2'b00, 3'b000, 32'h80, 32'h0, 0, 0, 32'h0, 2'b00, 0,
             1, 1, 0, 32'h80, 4'b1111, 32'h0, 2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_drops_strobes", 32'({bus_if.mem_read, bus_if.mem_write}), 32'd0);
        bus_if.mem_resp  = 1'b1;
        bus_if.mem_rdata = 32'h7777_7777;
        rst = 1'b1;
        @(negedge clk);
        bus_if.mem_resp = 1'b0;
        check("no_resp_after_reset", 32'(bus_if.resp_valid), 32'd0);
        check("ready_after_reset", 32'(bus_if.req_ready), 32'd1);

        // normal operation resumes after reset
        send(2'b00, 3'b010, 32'h0, 32'h0, 1, 0, 32'h0000_0013, 2'b00, 2,
             1, 1, 0, 32'h0, 4'b1111, 32'h0, 1);
        mem_reply(0, 32'h0000_0013);
        chk_idle(1, 32'h0000_0013, 0, 2'b00);

        repeat (5) @(negedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
